alu_pipe_nb: RTL and testbench
==============================

ALU_PIPE_NB -- requirements
Module: alu_pipe_nb

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits (W >= 2).
REQ-002 SHALL have localparam RW = 2*(W+1), the result width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports x0, x1, y0, y1  input  W  unsigned operands.
REQ-006 SHALL have port ctrl  input  alu_pkg::alu_pipe_ctrl_t  control word, sampled only on command accept.
REQ-007 SHALL have port cmd_valid  input  1  a command is offered.
REQ-008 SHALL have port cmd_ready  output  1  the block accepts a command this cycle.
REQ-009 SHALL have port res_valid  output  1  res_q and carry_q hold a valid result.
REQ-010 SHALL have port res_ready  input  1  the consumer takes the result this cycle.
REQ-011 SHALL have port res_q  output  RW  registered result.
REQ-012 SHALL have port carry_q  output  1  registered carry or borrow.

Function
REQ-013 Pre-adder per lane SHALL output zero-extended in0 when disabled; otherwise in0+in1, or in0-in1 when sub is set, in W+1 bits, mod 2^(W+1).
REQ-014 Multiplier m0 SHALL be the lane pre-adder output; m1 select SHALL be 0=in0, 1=in1, 2=pre-adder output, 3=the other lane's in1, 4=constant 1, else 0, each zero-extended to W+1 bits.
REQ-015 Multiplier SHALL output m0*m1 (RW bits) when enabled, otherwise the concatenation {m0,m1}.
REQ-016 Post-adder SHALL output {a[W:0],b[W:0]} with carry 0 when disabled; otherwise a+b or a-b in RW+1 bits, with bit RW as carry/borrow.
REQ-017 Stage 1 SHALL register both lane products plus the post, accumulate-enable and accumulate-clear controls on accept; stage 2 SHALL register the post-add/accumulate result.
REQ-018 A command SHALL be accepted when cmd_valid && cmd_ready; its result SHALL appear with res_valid high 2 cycles later when not stalled.
REQ-019 s2_ready SHALL be !s2_valid || res_ready, and cmd_ready SHALL be !s1_valid || s2_ready (combinational, no cmd_valid dependence); sustained throughput SHALL be 1 command per cycle.
REQ-020 With res_valid high and res_ready low, res_q, carry_q and res_valid SHALL hold stable; with both stages full, at most 2 commands SHALL be in flight.
REQ-021 A simultaneous consume and stage-1 advance SHALL load the new result with no bubble; results SHALL leave in accept order.
REQ-022 On a stage-2 load with acc_en: res = post + (acc_clr ? 0 : acc) mod 2^RW; carry_q = post carry OR accumulate carry-out; the accumulator SHALL take res.
REQ-023 Without acc_en, the accumulator SHALL hold, and res/carry SHALL be the post-adder output.

Reset
REQ-024 While rst is high on a clock edge: s1_valid=0, s2_valid=0, res_q=0, carry_q=0, accumulator=0; any in-flight commands SHALL be discarded.
REQ-025 cmd_ready SHALL be 1 in the first cycle after rst deasserts; res_valid SHALL be 0 until a post-reset command completes.

Structure
REQ-026 alu_pkg SHALL hold alu_pipe_ctrl_t: per-lane pre_en/pre_sub/mul_en/mul_sel[2:0], post_en, post_sub, acc_en, acc_clr.
REQ-027 alu_pkg SHALL hold the mul-select encodings as named constants.
REQ-028 SHALL instantiate sub-module alu_pipe_lane (parametrised pre-adder plus multiplier) twice, once for the x lane and once for the y lane.

Verification (W=4)
REQ-029 Basic: x0=3, x1=2 pre add; y0=4, y1=1 pre sub; both mul sel=4; post add -> res_q=8, carry_q=0, res_valid 2 cycles after accept.
REQ-030 Borrow: x path yields 3, y path yields 8, post sub -> res_q=1019 (0x3FB), carry_q=1.
REQ-031 Max operands: all operands 15, pre add, mul sel=2 both lanes, post add -> res_q=776, carry_q=1.
REQ-032 Backpressure: res_ready=0, 3 back-to-back commands -> 2 accepted, cmd_ready=0; release -> results in order, 1 per cycle, no loss or duplication.
REQ-033 Accumulate: post results 5, 7, 9 with acc_en, first with acc_clr -> res_q 5, 12, 21.
REQ-034 Reset mid-operation: rst for 1 cycle with both stages valid -> next cycle res_valid=0, cmd_ready=1; next acc_en command without acc_clr returns the post result unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: control word layout and multiplier-select encodings for alu_pipe_nb
package alu_pkg;
  localparam logic [2:0] SEL_IN0   = 3'd0;
  localparam logic [2:0] SEL_IN1   = 3'd1;
  localparam logic [2:0] SEL_PRE   = 3'd2;
  localparam logic [2:0] SEL_OTHER = 3'd3;
  localparam logic [2:0] SEL_ONE   = 3'd4;
  typedef struct packed {
    logic       pre_en;
    logic       pre_sub;
    logic       mul_en;
    logic [2:0] mul_sel;
  } lane_ctrl_t;
  typedef struct packed {
    lane_ctrl_t x;
    lane_ctrl_t y;
    logic       post_en;
    logic       post_sub;
    logic       acc_en;
    logic       acc_clr;
  } alu_pipe_ctrl_t;
endpackage

// File: rtl/alu_pipe_lane.sv
// alu_pipe_lane: per-lane pre-adder feeding a selectable-operand multiplier
module alu_pipe_lane
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]       in0_i,
  input  logic [W-1:0]       in1_i,
  input  logic [W-1:0]       oth_i,
  input  lane_ctrl_t         ctrl_i,
  output logic [2*(W+1)-1:0] prod_o
);
  localparam int RW = 2*(W+1);
  logic [W:0] a, b, o, pre, m1;
  // pre-add, pick the second multiplier operand, then multiply or pack both operands
  always_comb begin
    a = {1'b0, in0_i};
    b = {1'b0, in1_i};
    o = {1'b0, oth_i};
    pre = !ctrl_i.pre_en ? a : ctrl_i.pre_sub ? a - b : a + b;
    m1 = ctrl_i.mul_sel == SEL_IN0   ? a :
         ctrl_i.mul_sel == SEL_IN1   ? b :
         ctrl_i.mul_sel == SEL_PRE   ? pre :
         ctrl_i.mul_sel == SEL_OTHER ? o :
         ctrl_i.mul_sel == SEL_ONE   ? {{W{1'b0}}, 1'b1} : '0;
    prod_o = ctrl_i.mul_en ? RW'(pre) * RW'(m1) : {pre, m1};
  end
endmodule

// File: rtl/alu_pipe_nb.sv
// alu_pipe_nb: two-lane pre-add/multiply, post-add and accumulate in a 2-stage valid/ready pipeline
module alu_pipe_nb
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       x0,
  input  logic [W-1:0]       x1,
  input  logic [W-1:0]       y0,
  input  logic [W-1:0]       y1,
  input  alu_pipe_ctrl_t     ctrl,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*(W+1)-1:0] res_q,
  output logic               carry_q
);
  localparam int RW = 2*(W+1);
  logic [RW-1:0] px, py, pa_q, pb_q, acc_q, acc_in, res_d;
  logic [RW:0]   post, sum;
  logic          post_en_q, post_sub_q, acc_en_q, acc_clr_q;
  logic          s1_valid_q, s2_valid_q, s2_ready, accept, advance, carry_d;
  alu_pipe_lane #(.W(W)) u_x (.in0_i(x0), .in1_i(x1), .oth_i(y1), .ctrl_i(ctrl.x), .prod_o(px));
  alu_pipe_lane #(.W(W)) u_y (.in0_i(y0), .in1_i(y1), .oth_i(x1), .ctrl_i(ctrl.y), .prod_o(py));
  assign res_valid = s2_valid_q;
  // handshake and stage-2 post-add/accumulate datapath
  always_comb begin
    s2_ready = !s2_valid_q || res_ready;
    cmd_ready = !s1_valid_q || s2_ready;
    accept = cmd_valid && cmd_ready;
    advance = s1_valid_q && s2_ready;
    post = !post_en_q ? {1'b0, pa_q[W:0], pb_q[W:0]} :
           post_sub_q ? {1'b0, pa_q} - {1'b0, pb_q} : {1'b0, pa_q} + {1'b0, pb_q};
    acc_in = acc_clr_q ? '0 : acc_q;
    sum = {1'b0, post[RW-1:0]} + {1'b0, acc_in};
    res_d = acc_en_q ? sum[RW-1:0] : post[RW-1:0];
    carry_d = acc_en_q ? post[RW] | sum[RW] : post[RW];
  end
  // stage 1 captures lane products and controls on accept; stage 2 captures the result on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q <= '0;
      carry_q <= 1'b0;
      acc_q <= '0;
    end else begin
      s1_valid_q <= accept || (s1_valid_q && !s2_ready);
      s2_valid_q <= s2_ready ? s1_valid_q : s2_valid_q;
      if (accept) begin
        pa_q <= px;
        pb_q <= py;
        post_en_q <= ctrl.post_en;
        post_sub_q <= ctrl.post_sub;
        acc_en_q <= ctrl.acc_en;
        acc_clr_q <= ctrl.acc_clr;
      end
      if (advance) begin
        res_q <= res_d;
        carry_q <= carry_d;
        if (acc_en_q) acc_q <= res_d;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe_nb.sv
// tb_alu_pipe_nb: directed and randomized checks of alu_pipe_nb against an arithmetic reference model
module tb_alu_pipe_nb;
  import alu_pkg::*;
  localparam int W = 4;
  localparam int RW = 2*(W+1);
  localparam int M = 1 << (W+1);
  localparam int R = 1 << RW;
  logic clk = 0, rst = 1;
  logic [W-1:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  alu_pipe_ctrl_t ctrl = '0;
  logic cmd_valid = 0, res_ready = 1;
  logic cmd_ready, res_valid, carry_q;
  logic [RW-1:0] res_q;
  int n_chk = 0, n_err = 0, mdl_acc = 0;
  int q[$];
  bit post_rst = 0;

  alu_pipe_nb #(.W(W)) dut (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .ctrl(ctrl),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_q(res_q), .carry_q(carry_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int lane(input int a0, input int a1, input int o1, input lane_ctrl_t l);
    int p, m;
    p = !l.pre_en ? a0 : l.pre_sub ? a0 - a1 : a0 + a1;
    p = ((p % M) + M) % M;
    case (l.mul_sel)
      3'd0: m = a0;
      3'd1: m = a1;
      3'd2: m = p;
      3'd3: m = o1;
      3'd4: m = 1;
      default: m = 0;
    endcase
    return l.mul_en ? p * m : p * M + m;
  endfunction

  function automatic int model(input alu_pipe_ctrl_t c);
    int a, b, pv, pc, s;
    a = lane(int'(x0), int'(x1), int'(y1), c.x);
    b = lane(int'(y0), int'(y1), int'(x1), c.y);
    if (!c.post_en) begin
      pv = (a % M) * M + (b % M);
      pc = 0;
    end else if (c.post_sub) begin
      pv = (a - b + R) % R;
      pc = int'(a < b);
    end else begin
      pv = (a + b) % R;
      pc = int'(a + b >= R);
    end
    if (c.acc_en) begin
      s = pv + (c.acc_clr ? 0 : mdl_acc);
      pc = pc | int'(s >= R);
      pv = s % R;
      mdl_acc = pv;
    end
    return pc * R + pv;
  endfunction

  // scoreboard: queue expected results at accept, compare every valid result cycle
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mdl_acc = 0;
      post_rst = 1;
    end else begin
      if (post_rst) begin
        check("after_rst_cmd_ready", 32'(cmd_ready), 1);
        check("after_rst_res_valid", 32'(res_valid), 0);
        post_rst = 0;
      end
      if (res_valid) begin
        if (q.size() == 0) check("res_valid_unexpected", 32'(res_valid), 0);
        else begin
          check("result", 32'({carry_q, res_q}), q[0]);
          if (res_ready) void'(q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        q.push_back(model(ctrl));
        check("in_flight_le_2", 32'(q.size() <= 2), 1);
      end
    end
  end

  function automatic alu_pipe_ctrl_t mk(input logic [5:0] xl, input logic [5:0] yl, input logic [3:0] p);
    alu_pipe_ctrl_t c;
    c.x = xl;
    c.y = yl;
    {c.post_en, c.post_sub, c.acc_en, c.acc_clr} = p;
    return c;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int c, input int d, input alu_pipe_ctrl_t k);
    x0 = W'(a); x1 = W'(b); y0 = W'(c); y1 = W'(d); ctrl = k;
  endtask

  task automatic issue(input int a, input int b, input int c, input int d, input alu_pipe_ctrl_t k);
    bit ok = 0;
    drive(a, b, c, d, k);
    cmd_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      cyc();
    end
    cmd_valid = 0;
    check("issue_accepted", 32'(ok), 1);
  endtask

  task automatic wait_res(input string nm, input int r, input int c);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1;
        check(nm, 32'(res_q), r);
        check({nm, "_carry"}, 32'(carry_q), c);
      end
    end
    check({nm, "_seen"}, 32'(got), 1);
  endtask

  localparam logic [5:0] L_ADD1 = 6'b101_100, L_SUB1 = 6'b111_100, L_SQR = 6'b101_010;

  initial begin
    repeat (3) cyc();
    rst = 0;
    @(negedge clk);
    check("reset_res_q", 32'(res_q), 0);
    check("reset_carry_q", 32'(carry_q), 0);
    cyc();
    drive(3, 2, 4, 1, mk(L_ADD1, L_SUB1, 4'b1000));
    cmd_valid = 1;
    @(negedge clk);
    check("basic_cmd_ready", 32'(cmd_ready), 1);
    cyc();
    cmd_valid = 0;
    @(negedge clk);
    check("basic_lat1_valid", 32'(res_valid), 0);
    @(negedge clk);
    check("basic_lat2_valid", 32'(res_valid), 1);
    check("basic_res", 32'(res_q), 8);
    check("basic_carry", 32'(carry_q), 0);
    cyc();
    issue(3, 0, 8, 0, mk(L_ADD1, L_ADD1, 4'b1100));
    wait_res("borrow", 1019, 1);
    cyc();
    issue(15, 15, 15, 15, mk(L_SQR, L_SQR, 4'b1000));
    wait_res("max", 776, 1);
    cyc();
    issue(5, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1011));
    wait_res("acc1", 5, 0);
    cyc();
    issue(7, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1010));
    wait_res("acc2", 12, 0);
    cyc();
    issue(9, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1010));
    wait_res("acc3", 21, 0);
    cyc();
    res_ready = 0;
    cmd_valid = 1;
    drive(1, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1000));
    @(negedge clk);
    check("bp_accept1", 32'(cmd_ready), 1);
    cyc();
    drive(2, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1000));
    @(negedge clk);
    check("bp_accept2", 32'(cmd_ready), 1);
    cyc();
    drive(3, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1000));
    @(negedge clk);
    check("bp_full_ready", 32'(cmd_ready), 0);
    check("bp_hold_res", 32'(res_q), 1);
    cyc();
    @(negedge clk);
    check("bp_still_full", 32'(cmd_ready), 0);
    check("bp_still_hold", 32'(res_q), 1);
    check("bp_still_valid", 32'(res_valid), 1);
    cyc();
    res_ready = 1;
    @(negedge clk);
    check("bp_release_ready", 32'(cmd_ready), 1);
    check("bp_out1", 32'(res_q), 1);
    cyc();
    cmd_valid = 0;
    @(negedge clk);
    check("bp_out2", 32'(res_q), 2);
    cyc();
    @(negedge clk);
    check("bp_out3", 32'(res_q), 3);
    cyc();
    @(negedge clk);
    check("bp_drained", 32'(res_valid), 0);
    cyc();
    res_ready = 0;
    issue(3, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1010));
    issue(4, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1010));
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    check("midrst_valid", 32'(res_valid), 0);
    check("midrst_ready", 32'(cmd_ready), 1);
    cyc();
    res_ready = 1;
    issue(6, 0, 0, 0, mk(L_ADD1, L_ADD1, 4'b1010));
    wait_res("midrst_acc", 6, 0);
    cyc();
    cmd_valid = 1;
    for (int i = 0; i < 20; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, mk(6'($urandom), 6'($urandom), 4'($urandom)));
      @(negedge clk);
      check("stream_ready", 32'(cmd_ready), 1);
      if (i >= 2) check("stream_valid", 32'(res_valid), 1);
      cyc();
    end
    cmd_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      drive($urandom, $urandom, $urandom, $urandom, mk(6'($urandom), 6'($urandom), 4'($urandom)));
      cyc();
    end
    rst = 0;
    cmd_valid = 0;
    res_ready = 1;
    repeat (6) cyc();
    check("final_drain", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
